// File: rtl/hazard_pkg.sv
// Shared types for the hazard / forwarding controller.
// Shadow-stage entry, forward-select constant and stall cause.
package hazard_pkg;

  localparam int RD_MAX_W = 8;
  localparam int FWD_RF   = 0;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                regwrite;
    logic                memread;
  } stage_entry_t;

  typedef enum logic [1:0] {
    ADV,
    LOADUSE,
    BUSY,
    FLUSH
  } stall_cause_e;

endpackage

// File: rtl/fwd_prio_enc.sv
// Forward-source priority encoder.
// Lowest set hit bit (youngest stage) wins; none selects the regfile.
module fwd_prio_enc
  import hazard_pkg::*;
#(
  parameter  int DEPTH = 3,
  localparam int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0] hit,
  output logic [SEL_W-1:0] sel
);

  always_comb begin
    sel = SEL_W'(FWD_RF);
    for (int k = DEPTH; k >= 1; k--) begin
      if (hit[k-1]) sel = SEL_W'(k);
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller beside ID/EX.
// Shadow dest pipeline, forward selects, load-use/multi-cycle stall, flush.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter  int REG_AW    = 5,
  parameter  int FWD_DEPTH = 3,
  parameter  int MUL_LAT   = 4,
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              id_multi_i,
  input  logic              br_taken_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              if_id_flush_o,
  output logic              id_ex_bubble_o,
  output logic [SEL_W-1:0]  fwd_a_o,
  output logic [SEL_W-1:0]  fwd_b_o,
  output logic              ex_busy_o
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  stage_entry_t        stg [FWD_DEPTH+1];
  logic [RD_MAX_W-1:0] ex_rs1;
  logic [RD_MAX_W-1:0] ex_rs2;
  logic [CNT_W-1:0]    cnt;

  logic [RD_MAX_W-1:0] id_rs1;
  logic [RD_MAX_W-1:0] id_rs2;
  logic                busy;
  logic                br_go;
  logic                ld_use;
  logic                ld_go;
  stall_cause_e        cause;
  stage_entry_t        id_ent;
  logic [FWD_DEPTH-1:0] hit_a;
  logic [FWD_DEPTH-1:0] hit_b;

  assign id_rs1 = RD_MAX_W'(id_rs1_i);
  assign id_rs2 = RD_MAX_W'(id_rs2_i);
  assign busy   = cnt != '0;
  assign br_go  = br_taken_i & ~busy;

  assign ld_use = id_valid_i & stg[0].valid & stg[0].memread
                & (stg[0].rd != '0)
                & ((stg[0].rd == id_rs1) | (stg[0].rd == id_rs2));
  assign ld_go  = ld_use & ~busy & ~br_go;

  always_comb begin
    cause = ADV;
    unique case (1'b1)
      busy:    cause = BUSY;
      br_go:   cause = FLUSH;
      ld_go:   cause = LOADUSE;
      default: cause = ADV;
    endcase
  end

  assign pc_write_o     = (cause == ADV) | (cause == FLUSH);
  assign if_id_write_o  = (cause == ADV) | (cause == FLUSH);
  assign if_id_flush_o  = cause == FLUSH;
  assign id_ex_bubble_o = (cause == FLUSH) | (cause == LOADUSE);
  assign ex_busy_o      = busy;

  // A bubbled slot carries no controls at all
  always_comb begin
    id_ent          = '0;
    id_ent.valid    = id_valid_i & ~id_ex_bubble_o;
    id_ent.rd       = RD_MAX_W'(id_rd_i);
    id_ent.regwrite = id_regwrite_i & id_ent.valid;
    id_ent.memread  = id_memread_i & id_ent.valid;
  end

  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int k = 1; k <= FWD_DEPTH; k++) begin
      hit_a[k-1] = stg[k].valid & stg[k].regwrite
                 & (stg[k].rd != '0) & (stg[k].rd == ex_rs1);
      hit_b[k-1] = stg[k].valid & stg[k].regwrite
                 & (stg[k].rd != '0) & (stg[k].rd == ex_rs2);
    end
  end

  fwd_prio_enc #(.DEPTH(FWD_DEPTH)) u_enc_a (
    .hit (hit_a),
    .sel (fwd_a_o)
  );

  fwd_prio_enc #(.DEPTH(FWD_DEPTH)) u_enc_b (
    .hit (hit_b),
    .sel (fwd_b_o)
  );

  // While busy, EX holds and an empty slot moves down behind it
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k <= FWD_DEPTH; k++) stg[k] <= '0;
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      cnt    <= '0;
    end else if (busy) begin
      cnt    <= cnt - CNT_W'(1);
      stg[1] <= '0;
      for (int k = 2; k <= FWD_DEPTH; k++) stg[k] <= stg[k-1];
    end else begin
      for (int k = 1; k <= FWD_DEPTH; k++) stg[k] <= stg[k-1];
      stg[0] <= id_ent;
      ex_rs1 <= id_rs1;
      ex_rs2 <= id_rs2;
      if (id_ent.valid & id_multi_i) cnt <= CNT_W'(MUL_LAT - 1);
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl.
// Main build (depth 3, lat 4) plus a depth-1 build on shared stimulus.
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic [4:0] id_rd = '0;
  logic       id_rw = 1'b0;
  logic       id_mr = 1'b0;
  logic       id_mu = 1'b0;
  logic       br = 1'b0;

  logic       pc_w, ifid_w, flush, bubble, busy;
  logic [1:0] fwd_a, fwd_b;
  logic       p1_pc_w, p1_ifid_w, p1_flush, p1_bubble, p1_busy;
  logic [0:0] p1_fwd_a, p1_fwd_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.REG_AW(5), .FWD_DEPTH(3), .MUL_LAT(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_regwrite_i(id_rw), .id_memread_i(id_mr),
    .id_multi_i(id_mu), .br_taken_i(br),
    .pc_write_o(pc_w), .if_id_write_o(ifid_w),
    .if_id_flush_o(flush), .id_ex_bubble_o(bubble),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .ex_busy_o(busy)
  );

  hazard_fwd_ctrl #(.REG_AW(5), .FWD_DEPTH(1), .MUL_LAT(4)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_regwrite_i(id_rw), .id_memread_i(id_mr),
    .id_multi_i(id_mu), .br_taken_i(br),
    .pc_write_o(p1_pc_w), .if_id_write_o(p1_ifid_w),
    .if_id_flush_o(p1_flush), .id_ex_bubble_o(p1_bubble),
    .fwd_a_o(p1_fwd_a), .fwd_b_o(p1_fwd_b), .ex_busy_o(p1_busy)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mu);
    id_valid = v;
    id_rs1 = r1;
    id_rs2 = r2;
    id_rd = rd;
    id_rw = rw;
    id_mr = mr;
    id_mu = mu;
  endtask

  task automatic nop;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear;
    nop();
    br = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_reset;
    #2 rst_i = 1'b0;
    #1;
    n_cmp++; if (pc_w !== 1'b1) begin n_bad++;
      $display("FAIL rst_pc: got %b want 1", pc_w); end
    n_cmp++; if (ifid_w !== 1'b1) begin n_bad++;
      $display("FAIL rst_ifid: got %b want 1", ifid_w); end
    n_cmp++; if (flush !== 1'b0) begin n_bad++;
      $display("FAIL rst_flush: got %b want 0", flush); end
    n_cmp++; if (bubble !== 1'b0) begin n_bad++;
      $display("FAIL rst_bubble: got %b want 0", bubble); end
    n_cmp++; if (fwd_a !== 2'd0) begin n_bad++;
      $display("FAIL rst_fwd_a: got %0d want 0", fwd_a); end
    n_cmp++; if (fwd_b !== 2'd0) begin n_bad++;
      $display("FAIL rst_fwd_b: got %0d want 0", fwd_b); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL rst_busy: got %b want 0", busy); end
    tick();
    rst_i = 1'b1;
  endtask

  task automatic test_forward;
    clear();
    drive(1, 1, 2, 5, 1, 0, 0);
    tick();
    drive(1, 5, 1, 6, 1, 0, 0);
    tick();
    nop(); #1;
    n_cmp++; if (fwd_a !== 2'd1) begin n_bad++;
      $display("FAIL fwd_mem_a: got %0d want 1", fwd_a); end
    n_cmp++; if (fwd_b !== 2'd0) begin n_bad++;
      $display("FAIL fwd_mem_b: got %0d want 0", fwd_b); end
    clear();
    drive(1, 1, 2, 5, 1, 0, 0);
    tick();
    nop();
    tick();
    drive(1, 5, 1, 6, 1, 0, 0);
    tick();
    nop(); #1;
    n_cmp++; if (fwd_a !== 2'd2) begin n_bad++;
      $display("FAIL fwd_wb_a: got %0d want 2", fwd_a); end
    clear();
    drive(1, 1, 2, 0, 1, 0, 0);
    tick();
    drive(1, 0, 0, 6, 1, 0, 0);
    tick();
    nop(); #1;
    n_cmp++; if (fwd_a !== 2'd0) begin n_bad++;
      $display("FAIL fwd_x0_a: got %0d want 0", fwd_a); end
    n_cmp++; if (fwd_b !== 2'd0) begin n_bad++;
      $display("FAIL fwd_x0_b: got %0d want 0", fwd_b); end
    clear();
    drive(1, 1, 2, 5, 0, 0, 0);
    tick();
    drive(1, 5, 5, 6, 1, 0, 0);
    tick();
    nop(); #1;
    n_cmp++; if (fwd_a !== 2'd0) begin n_bad++;
      $display("FAIL fwd_norw_a: got %0d want 0", fwd_a); end
  endtask

  task automatic test_youngest;
    clear();
    drive(1, 1, 2, 5, 1, 0, 0);
    tick();
    drive(1, 3, 4, 5, 1, 0, 0);
    tick();
    drive(1, 5, 5, 6, 1, 0, 0);
    tick();
    nop(); #1;
    n_cmp++; if (fwd_a !== 2'd1) begin n_bad++;
      $display("FAIL young_a: got %0d want 1", fwd_a); end
    n_cmp++; if (fwd_b !== 2'd1) begin n_bad++;
      $display("FAIL young_b: got %0d want 1", fwd_b); end
  endtask

  task automatic test_load_use;
    clear();
    drive(1, 1, 0, 5, 1, 1, 0);
    tick();
    drive(1, 5, 5, 6, 1, 0, 0);
    #1;
    n_cmp++; if (pc_w !== 1'b0) begin n_bad++;
      $display("FAIL lu_pc: got %b want 0", pc_w); end
    n_cmp++; if (ifid_w !== 1'b0) begin n_bad++;
      $display("FAIL lu_ifid: got %b want 0", ifid_w); end
    n_cmp++; if (bubble !== 1'b1) begin n_bad++;
      $display("FAIL lu_bubble: got %b want 1", bubble); end
    n_cmp++; if (flush !== 1'b0) begin n_bad++;
      $display("FAIL lu_flush: got %b want 0", flush); end
    tick(); #1;
    n_cmp++; if (pc_w !== 1'b1) begin n_bad++;
      $display("FAIL lu_pc2: got %b want 1", pc_w); end
    n_cmp++; if (bubble !== 1'b0) begin n_bad++;
      $display("FAIL lu_bubble2: got %b want 0", bubble); end
    tick();
    nop(); #1;
    n_cmp++; if (fwd_a !== 2'd2) begin n_bad++;
      $display("FAIL lu_fwd_a: got %0d want 2", fwd_a); end
    n_cmp++; if (fwd_b !== 2'd2) begin n_bad++;
      $display("FAIL lu_fwd_b: got %0d want 2", fwd_b); end
    clear();
    drive(1, 1, 0, 0, 1, 1, 0);
    tick();
    drive(1, 0, 0, 6, 1, 0, 0);
    #1;
    n_cmp++; if (pc_w !== 1'b1) begin n_bad++;
      $display("FAIL lu_x0_pc: got %b want 1", pc_w); end
    n_cmp++; if (bubble !== 1'b0) begin n_bad++;
      $display("FAIL lu_x0_bubble: got %b want 0", bubble); end
  endtask

  task automatic test_multi;
    int n;
    clear();
    drive(1, 1, 2, 7, 1, 0, 1);
    tick();
    drive(1, 7, 0, 8, 1, 0, 0);
    br = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++;
      $display("FAIL mul_busy: got %b want 1", busy); end
    n_cmp++; if (pc_w !== 1'b0) begin n_bad++;
      $display("FAIL mul_pc: got %b want 0", pc_w); end
    n_cmp++; if (ifid_w !== 1'b0) begin n_bad++;
      $display("FAIL mul_ifid: got %b want 0", ifid_w); end
    n_cmp++; if (flush !== 1'b0) begin n_bad++;
      $display("FAIL mul_br_ign: got %b want 0", flush); end
    n_cmp++; if (bubble !== 1'b0) begin n_bad++;
      $display("FAIL mul_bubble: got %b want 0", bubble); end
    br = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 8) begin
      n++;
      tick(); #1;
    end
    n_cmp++; if (n != 3) begin n_bad++;
      $display("FAIL mul_cycles: got %0d want 3", n); end
    n_cmp++; if (pc_w !== 1'b1) begin n_bad++;
      $display("FAIL mul_release: got %b want 1", pc_w); end
    tick();
    nop(); #1;
    n_cmp++; if (fwd_a !== 2'd1) begin n_bad++;
      $display("FAIL mul_fwd_a: got %0d want 1", fwd_a); end
    n_cmp++; if (fwd_b !== 2'd0) begin n_bad++;
      $display("FAIL mul_fwd_b: got %0d want 0", fwd_b); end
  endtask

  task automatic test_branch;
    clear();
    drive(1, 1, 0, 5, 1, 1, 0);
    tick();
    drive(1, 5, 5, 6, 1, 0, 0);
    br = 1'b1;
    #1;
    n_cmp++; if (flush !== 1'b1) begin n_bad++;
      $display("FAIL br_flush: got %b want 1", flush); end
    n_cmp++; if (bubble !== 1'b1) begin n_bad++;
      $display("FAIL br_bubble: got %b want 1", bubble); end
    n_cmp++; if (pc_w !== 1'b1) begin n_bad++;
      $display("FAIL br_pc: got %b want 1", pc_w); end
    tick();
    br = 1'b0;
    nop(); #1;
    n_cmp++; if (flush !== 1'b0) begin n_bad++;
      $display("FAIL br_flush2: got %b want 0", flush); end
    n_cmp++; if (bubble !== 1'b0) begin n_bad++;
      $display("FAIL br_bubble2: got %b want 0", bubble); end
  endtask

  task automatic test_reset_mid_stall;
    clear();
    drive(1, 1, 2, 5, 1, 0, 0);
    tick();
    drive(1, 5, 0, 9, 1, 1, 0);
    tick();
    drive(1, 9, 0, 10, 1, 0, 0);
    #1;
    n_cmp++; if (fwd_a !== 2'd1) begin n_bad++;
      $display("FAIL rms_pre_fwd: got %0d want 1", fwd_a); end
    n_cmp++; if (pc_w !== 1'b0) begin n_bad++;
      $display("FAIL rms_pre_pc: got %b want 0", pc_w); end
    rst_i = 1'b0;
    tick(); #1;
    n_cmp++; if (pc_w !== 1'b1) begin n_bad++;
      $display("FAIL rms_pc: got %b want 1", pc_w); end
    n_cmp++; if (ifid_w !== 1'b1) begin n_bad++;
      $display("FAIL rms_ifid: got %b want 1", ifid_w); end
    n_cmp++; if (bubble !== 1'b0) begin n_bad++;
      $display("FAIL rms_bubble: got %b want 0", bubble); end
    n_cmp++; if (fwd_a !== 2'd0) begin n_bad++;
      $display("FAIL rms_fwd_a: got %0d want 0", fwd_a); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL rms_busy: got %b want 0", busy); end
    rst_i = 1'b1;
    nop();
    tick();
  endtask

  task automatic test_depth1;
    clear();
    drive(1, 1, 2, 5, 1, 0, 0);
    tick();
    drive(1, 5, 1, 6, 1, 0, 0);
    tick();
    nop(); #1;
    n_cmp++; if (p1_fwd_a !== 1'b1) begin n_bad++;
      $display("FAIL d1_near: got %0d want 1", p1_fwd_a); end
    clear();
    drive(1, 1, 2, 5, 1, 0, 0);
    tick();
    nop();
    tick();
    drive(1, 5, 1, 6, 1, 0, 0);
    tick();
    nop(); #1;
    n_cmp++; if (p1_fwd_a !== 1'b0) begin n_bad++;
      $display("FAIL d1_far: got %0d want 0", p1_fwd_a); end
    n_cmp++; if (fwd_a !== 2'd2) begin n_bad++;
      $display("FAIL d3_far: got %0d want 2", fwd_a); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_youngest();
    test_load_use();
    test_multi();
    test_branch();
    test_reset_mid_stall();
    test_depth1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
